instr_dispatch_ctrl: RTL

Sequences the instruction-frame memory for the core array. Reads each frame's 3-word header (fence, instruction count, exec mask, r0 init vector), then streams the frame's 32-bit instructions to the cores. Each instruction is broadcast to all cores and is accepted once every masked core is ready. At the end of each frame it applies the header's fence mode before loading the next frame.

---
 rtl/instr_dispatch_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instr_dispatch_ctrl.sv
// instr_dispatch_ctrl: reads each frame header, then streams its instructions to the core array and applies the frame fence.
// Ports: clk/rst (async active-high); start pulse; mem_rd/mem_addr/mem_rdata frame-memory read port (1-cycle latency);
// exec_mask/r0_init/frame_start current frame header; msg_valid/msg_data instruction broadcast gated by core_ready;
// core_done fence input; frame_idx/busy/halted status.
// Optional DISPATCH_PERF_CNT_EN adds saturating perf_issued/perf_stall counters.
module instr_dispatch_ctrl #(
  parameter int NCORES      = 16,
  parameter int ADDR_W      = 10,
  parameter int FRAME_WORDS = 256,
  parameter int NFRAMES     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       mem_rd,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [15:0]                mem_rdata,
  output logic [NCORES-1:0]          exec_mask,
  output logic [NCORES-1:0]          r0_init,
  output logic                       frame_start,
  output logic                       msg_valid,
  output logic [31:0]                msg_data,
  input  logic [NCORES-1:0]          core_ready,
  input  logic [NCORES-1:0]          core_done,
  output logic [$clog2(NFRAMES)-1:0] frame_idx,
  output logic                       busy,
  output logic                       halted
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [15:0]                perf_issued,
  output logic [15:0]                perf_stall
`endif
);
  localparam logic [3:0] IDLE = 4'd0, H0 = 4'd1, H1 = 4'd2, H2 = 4'd3, H3 = 4'd4, I0 = 4'd5,
                         I1 = 4'd6, I2 = 4'd7, OFFER = 4'd8, FENCE = 4'd9, HALT = 4'd10;
  localparam int FO_W = $clog2(FRAME_WORDS);
  logic [3:0] state_q, state_d;
  logic [1:0] fence_q, fence_d;
  logic [5:0] if_num_q, if_num_d, k_q, k_d;
  logic [NCORES-1:0] mask_q, mask_d, r0_q, r0_d;
  logic [15:0] lo_q, lo_d, hi_q, hi_d;
  logic [$clog2(NFRAMES)-1:0] fidx_q, fidx_d;
  logic accept, fence_ok;
  logic [ADDR_W-1:0] base, offset;
  assign accept   = &(core_ready | ~mask_q);
  assign fence_ok = fence_q == 2'd0 || (fence_q == 2'd1 && &(core_done | ~mask_q)) ||
                    (fence_q == 2'd2 && &core_done);
  assign base     = ADDR_W'(fidx_q) << FO_W;
  assign offset   = state_q == H1 ? ADDR_W'(1) :
                    state_q == H2 ? ADDR_W'(2) :
                    state_q == I0 ? ADDR_W'({k_q, 1'b0}) + ADDR_W'(4) :
                    state_q == I1 ? ADDR_W'({k_q, 1'b0}) + ADDR_W'(5) : '0;
  assign mem_rd      = state_q == H0 || state_q == H1 || state_q == H2 || state_q == I0 || state_q == I1;
  assign mem_addr    = mem_rd ? base + offset : '0;
  assign exec_mask   = mask_q;
  // r0_init is forwarded straight from memory in H3 so it is valid alongside frame_start.
  assign r0_init     = state_q == H3 ? NCORES'(mem_rdata) : r0_q;
  assign frame_start = state_q == H3;
  assign msg_valid   = state_q == OFFER;
  assign msg_data    = {hi_q, lo_q};
  assign frame_idx   = fidx_q;
  assign busy        = state_q != IDLE && state_q != HALT;
  assign halted      = state_q == HALT;
  always_comb begin
    state_d  = state_q;
    fence_d  = fence_q;
    if_num_d = if_num_q;
    k_d      = k_q;
    mask_d   = mask_q;
    r0_d     = r0_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    fidx_d   = fidx_q;
    case (state_q)
      IDLE: state_d = start ? H0 : IDLE;
      H0:   state_d = H1;
      H1: begin
        fence_d  = mem_rdata[7:6];
        if_num_d = mem_rdata[5:0];
        state_d  = H2;
      end
      H2: begin
        mask_d  = NCORES'(mem_rdata);
        state_d = H3;
      end
      H3: begin
        r0_d    = NCORES'(mem_rdata);
        k_d     = '0;
        state_d = if_num_q == 6'd0 ? FENCE : I0;
      end
      I0: state_d = I1;
      I1: begin
        lo_d    = mem_rdata;
        state_d = I2;
      end
      I2: begin
        hi_d    = mem_rdata;
        state_d = OFFER;
      end
      OFFER: if (accept) begin
        k_d     = k_q + 6'd1;
        state_d = k_q + 6'd1 == if_num_q ? FENCE : I0;
      end
      FENCE: if (fence_q == 2'd3) state_d = HALT;
             else if (fence_ok) begin
               fidx_d  = fidx_q + 1'b1;
               state_d = H0;
             end
      HALT: if (start) begin
        fidx_d  = fidx_q + 1'b1;
        state_d = H0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fence_q  <= '0;
      if_num_q <= '0;
      k_q      <= '0;
      mask_q   <= '0;
      r0_q     <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      fidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      fence_q  <= fence_d;
      if_num_q <= if_num_d;
      k_q      <= k_d;
      mask_q   <= mask_d;
      r0_q     <= r0_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      fidx_q   <= fidx_d;
    end
  end
`ifdef DISPATCH_PERF_CNT_EN
  logic [15:0] issued_q, issued_d, stall_q, stall_d;
  logic stall;
  // A fence=3 frame leaves FENCE for HALT, so it is not a stall.
  assign stall = (state_q == OFFER && !accept) || (state_q == FENCE && fence_q != 2'd3 && !fence_ok);
  always_comb begin
    issued_d = (state_q == OFFER && accept && ~&issued_q) ? issued_q + 16'd1 : issued_q;
    stall_d  = (stall && ~&stall_q) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end
  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`endif
endmodule
